sha_req_arbiter: RTL and testbench
==================================

SHA_REQ_ARBITER -- requirements
Module: sha_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one hash core, 2..8.
REQ-002 SHALL have parameter NK, default 256: hash width in bits, equal to the core's hash output width.
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum cycles waited for core completion, at least 2.
REQ-004 SHALL have port clk  input  1: clock, all state updated on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester hash request, held high until accepted.
REQ-007 SHALL have port req_ready  output  NREQ: one-hot acceptance pulse to the granted requester.
REQ-008 SHALL have port core_enable  output  1: single-cycle start pulse to the shared hash core.
REQ-009 SHALL have port core_sel  output  clog2(NREQ): index of the requester whose data feeds the core.
REQ-010 SHALL have port core_ready  input  1: core completion pulse.
REQ-011 SHALL have port core_hash  input  NK: core hash result, valid while core_ready is high.
REQ-012 SHALL have port rsp_valid  output  NREQ: one-hot single-cycle response pulse to the owning requester.
REQ-013 SHALL have port rsp_hash  output  NK: returned hash, valid while any rsp_valid bit is high.
REQ-014 SHALL have port rsp_error  output  1: timeout flag, qualified by rsp_valid.
REQ-015 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT and RESP, with at most one job outstanding.
REQ-017 SHALL, in IDLE with any req_valid high, grant the first set index scanning from rr_ptr upward with wrap-around, latch it as g, assert req_ready[g] combinationally in that cycle, and go to ISSUE.
REQ-018 SHALL stay in IDLE with all outputs at 0 when no req_valid bit is high.
REQ-019 SHALL, in ISSUE, assert core_enable for exactly one cycle, then go to WAIT and clear the timer.
REQ-020 SHALL drive core_sel = g from ISSUE through RESP inclusive, and 0 in IDLE.
REQ-021 SHALL, in WAIT on core_ready=1, latch core_hash, clear the error flag and go to RESP.
REQ-022 SHALL, in WAIT without core_ready, increment the timer; when the timer reaches TIMEOUT-1, latch a zero hash, set the error flag and go to RESP.
REQ-023 SHALL give core_ready priority over timeout expiry when both occur in the same cycle (success, no error).
REQ-024 SHALL ignore core_ready in IDLE, ISSUE and RESP.
REQ-025 SHALL, in RESP, pulse rsp_valid[g] for one cycle, drive rsp_hash and rsp_error from the latched values, set rr_ptr = (g+1) mod NREQ, and return to IDLE.
REQ-026 SHALL hold rsp_hash and rsp_error at 0 outside RESP; responses have no back-pressure.
REQ-027 SHALL have this latency: for a grant in cycle t, core_enable is high at t+1; if core_ready arrives at t+1+k (k>=1), rsp_valid is high at t+2+k.
REQ-028 SHALL accept no new request in the RESP cycle; the earliest next grant is the following IDLE cycle.
REQ-029 SHALL give each continuously requesting requester a grant within NREQ jobs (round-robin fairness).

Reset
REQ-030 SHALL, while rst=0, set state IDLE, rr_ptr 0, timer 0, latched hash 0 and error 0, and drive all outputs to 0.
REQ-031 SHALL, on reset during ISSUE, WAIT or RESP, abandon the job with no rsp_valid, and ignore any later core_ready until the next core_enable.

Verification
REQ-032 Single job: req_valid=0001 in cycle t; core_ready with core_hash=H at t+5 -> req_ready=0001 at t, core_enable at t+1, rsp_valid=0001 with rsp_hash=H and rsp_error=0 at t+6.
REQ-033 Round robin: req_valid=1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0, with exactly one core_enable per job.
REQ-034 Wrap: rr_ptr=3, req_valid=0101 -> grant 0, then rr_ptr=1, then grant 2.
REQ-035 Timeout: TIMEOUT=8, core_ready never asserted -> rsp_valid[g]=1 with rsp_error=1 and rsp_hash=0 eight cycles after core_enable; a core_ready on that final cycle instead gives rsp_error=0.
REQ-036 Reset mid-WAIT: rst=0 for one cycle, then a stale core_ready -> no rsp_valid, busy=0, next grant starts from index 0.
REQ-037 Idle noise: core_ready pulses with all req_valid=0 -> all outputs remain 0.

Source files
------------

// File: rtl/sha_req_arbiter.sv
// Round-robin arbiter sharing one hash core among NREQ requesters, one job in flight.
// Latency: grant at t, core_enable at t+1, response one cycle after core_ready; no response back-pressure.
module sha_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int NK      = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    output logic                      core_enable,
    output logic [$clog2(NREQ)-1:0]   core_sel,
    input  logic                      core_ready,
    input  logic [NK-1:0]             core_hash,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [NK-1:0]             rsp_hash,
    output logic                      rsp_error,
    output logic                      busy
);

    localparam int SW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NK-1:0] hash_q, hash_d;
    logic          err_q, err_d;

    logic          any_req;
    logic [SW-1:0] pick;
    logic [TW-1:0] timer_inc;
    logic [NREQ-1:0] one_hot_base;

    assign one_hot_base = {{(NREQ-1){1'b0}}, 1'b1};
    assign timer_inc    = timer_q + 1'b1;

    // First requester at or above rr_ptr, wrapping around to index 0.
    always_comb begin
        int j;
        any_req = 1'b0;
        pick    = '0;
        j       = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any_req && req_valid[j]) begin
                any_req = 1'b1;
                pick    = SW'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        timer_d  = timer_q;
        hash_d   = hash_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the expiry cycle still counts as success.
                if (core_ready) begin
                    hash_d  = core_hash;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(TIMEOUT - 1)) begin
                        hash_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                rr_ptr_d = (grant_q == SW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            timer_q  <= '0;
            hash_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            hash_q   <= hash_d;
            err_q    <= err_d;
        end
    end

    // Outputs are forced low during reset so an in-flight job vanishes immediately.
    always_comb begin
        req_ready   = '0;
        core_enable = 1'b0;
        core_sel    = '0;
        rsp_valid   = '0;
        rsp_hash    = '0;
        rsp_error   = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            busy = (state_q != IDLE);
            if (state_q == IDLE && any_req) begin
                req_ready = one_hot_base << pick;
            end
            if (state_q != IDLE) begin
                core_sel = grant_q;
            end
            if (state_q == ISSUE) begin
                core_enable = 1'b1;
            end
            if (state_q == RESP) begin
                rsp_valid = one_hot_base << grant_q;
                rsp_hash  = hash_q;
                rsp_error = err_q;
            end
        end
    end

endmodule

// File: tb/tb_sha_req_arbiter.sv
// Directed bench for sha_req_arbiter: per-cycle vector table plus round-robin and timeout sequences.
module tb_sha_req_arbiter;

    localparam int NREQ = 4;
    localparam int NK   = 32;
    localparam int TO   = 8;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic            core_enable;
    logic [1:0]      core_sel;
    logic            core_ready;
    logic [NK-1:0]   core_hash;
    logic [NREQ-1:0] rsp_valid;
    logic [NK-1:0]   rsp_hash;
    logic            rsp_error;
    logic            busy;

    int errors = 0;
    int checks = 0;

    sha_req_arbiter #(.NREQ(NREQ), .NK(NK), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .core_enable(core_enable),
        .core_sel   (core_sel),
        .core_ready (core_ready),
        .core_hash  (core_hash),
        .rsp_valid  (rsp_valid),
        .rsp_hash   (rsp_hash),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic            cr;
        logic [NK-1:0]   hash;
        logic [NREQ-1:0] e_rdy;
        logic            e_en;
        logic [1:0]      e_sel;
        logic [NREQ-1:0] e_rsp;
        logic [NK-1:0]   e_hash;
        logic            e_err;
        logic            e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic c, logic [31:0] h,
                                logic [3:0] rdy, logic en, logic [1:0] sel,
                                logic [3:0] rsp, logic [31:0] eh, logic er, logic bz);
        vec_t v;
        v.rst = r; v.req = rq; v.cr = c; v.hash = h;
        v.e_rdy = rdy; v.e_en = en; v.e_sel = sel; v.e_rsp = rsp;
        v.e_hash = eh; v.e_err = er; v.e_busy = bz;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle and wait to the sampling point (falling edge).
    task automatic drive(logic r, logic [3:0] rq, logic c, logic [31:0] h);
        rst        = r;
        req_valid  = rq;
        core_ready = c;
        core_hash  = h;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] H0 = 32'h0BAD_F00D;
    localparam logic [31:0] H1 = 32'hDEAD_BEEF;
    localparam logic [31:0] H2 = 32'h1234_5678;
    localparam logic [31:0] H3 = 32'hCAFE_0001;
    localparam logic [31:0] H4 = 32'h5A5A_A5A5;
    localparam logic [31:0] H5 = 32'hFFFF_0000;
    localparam logic [31:0] H6 = 32'h0F0F_F0F0;
    localparam logic [31:0] H7 = 32'h7777_1111;

    initial begin
        int en_cnt;
        int exp_g;
        rst = 1'b0; req_valid = '0; core_ready = 1'b0; core_hash = '0;

        // rst req cr hash | rdy en sel rsp hash err busy
        tbl.push_back(mk(0, 4'hF,    1, H0, 4'b0000, 0, 0, 4'b0000, 0,  0, 0)); // reset gates outputs
        tbl.push_back(mk(0, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0000, 0,  0, 0));
        tbl.push_back(mk(1, 4'h0,    1, H0, 4'b0000, 0, 0, 4'b0000, 0,  0, 0)); // idle noise
        tbl.push_back(mk(1, 4'h0,    1, H0, 4'b0000, 0, 0, 4'b0000, 0,  0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, 0,  4'b0001, 0, 0, 4'b0000, 0,  0, 0)); // single job t
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 1, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    1, H1, 4'b0000, 0, 0, 4'b0000, 0,  0, 1)); // t+5
        tbl.push_back(mk(1, 4'b0010, 1, H0, 4'b0000, 0, 0, 4'b0001, H1, 0, 1)); // t+6, no grant in RESP
        tbl.push_back(mk(1, 4'b0010, 0, 0,  4'b0010, 0, 0, 4'b0000, 0,  0, 0));
        tbl.push_back(mk(1, 4'h0,    1, H0, 4'b0000, 1, 1, 4'b0000, 0,  0, 1)); // core_ready in ISSUE ignored
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 1, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    1, H2, 4'b0000, 0, 1, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 1, 4'b0010, H2, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 0, 0,  4'b0100, 0, 0, 4'b0000, 0,  0, 0));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 1, 2, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    1, H3, 4'b0000, 0, 2, 4'b0000, 0,  0, 1)); // k=1
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 2, 4'b0100, H3, 0, 1));
        tbl.push_back(mk(1, 4'b0101, 0, 0,  4'b0001, 0, 0, 4'b0000, 0,  0, 0)); // wrap from rr_ptr=3
        tbl.push_back(mk(1, 4'b0100, 0, 0,  4'b0000, 1, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'b0100, 1, H4, 4'b0000, 0, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'b0100, 0, 0,  4'b0000, 0, 0, 4'b0001, H4, 0, 1));
        tbl.push_back(mk(1, 4'b0100, 0, 0,  4'b0100, 0, 0, 4'b0000, 0,  0, 0));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 1, 2, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 2, 4'b0000, 0,  0, 1)); // WAIT
        tbl.push_back(mk(0, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0000, 0,  0, 0)); // reset mid-WAIT
        tbl.push_back(mk(1, 4'h0,    1, H5, 4'b0000, 0, 0, 4'b0000, 0,  0, 0)); // stale core_ready
        tbl.push_back(mk(1, 4'hF,    0, 0,  4'b0001, 0, 0, 4'b0000, 0,  0, 0)); // rr_ptr back at 0
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 1, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    1, H6, 4'b0000, 0, 0, 4'b0000, 0,  0, 1));
        tbl.push_back(mk(1, 4'h0,    0, 0,  4'b0000, 0, 0, 4'b0001, H6, 0, 1));
        tbl.push_back(mk(1, 4'h0,    1, H0, 4'b0000, 0, 0, 4'b0000, 0,  0, 0));

        adv();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].cr, tbl[i].hash);
            chk($sformatf("v%0d req_ready", i),   64'(req_ready),   64'(tbl[i].e_rdy));
            chk($sformatf("v%0d core_enable", i), 64'(core_enable), 64'(tbl[i].e_en));
            chk($sformatf("v%0d core_sel", i),    64'(core_sel),    64'(tbl[i].e_sel));
            chk($sformatf("v%0d rsp_valid", i),   64'(rsp_valid),   64'(tbl[i].e_rsp));
            chk($sformatf("v%0d rsp_hash", i),    64'(rsp_hash),    64'(tbl[i].e_hash));
            chk($sformatf("v%0d rsp_error", i),   64'(rsp_error),   64'(tbl[i].e_err));
            chk($sformatf("v%0d busy", i),        64'(busy),        64'(tbl[i].e_busy));
            adv();
        end

        // Round robin with all four requesting from rr_ptr=0: grants 0,1,2,3,0.
        drive(0, 4'h0, 0, 0);
        adv();
        for (int j = 0; j < 5; j++) begin
            exp_g  = j % NREQ;
            en_cnt = 0;
            drive(1, 4'hF, 0, 0);
            chk($sformatf("rr%0d grant", j), 64'(req_ready), 64'(1) << exp_g);
            en_cnt += int'(core_enable);
            adv();
            drive(1, 4'hF, 0, 0);
            chk($sformatf("rr%0d sel", j), 64'(core_sel), 64'(exp_g));
            en_cnt += int'(core_enable);
            adv();
            drive(1, 4'hF, 1, 32'(j + 100));
            en_cnt += int'(core_enable);
            adv();
            drive(1, 4'hF, 0, 0);
            chk($sformatf("rr%0d rsp_valid", j), 64'(rsp_valid), 64'(1) << exp_g);
            chk($sformatf("rr%0d rsp_hash", j), 64'(rsp_hash), 64'(j + 100));
            chk($sformatf("rr%0d no grant in RESP", j), 64'(req_ready), 64'(0));
            en_cnt += int'(core_enable);
            chk($sformatf("rr%0d enable count", j), 64'(en_cnt), 64'(1));
            adv();
        end

        // Timeout: rr_ptr=1, requester 1 alone, core never answers.
        drive(1, 4'b0010, 0, 0);
        chk("to grant", 64'(req_ready), 64'(4'b0010));
        adv();
        drive(1, 4'h0, 0, 0);
        chk("to enable", 64'(core_enable), 64'(1));
        adv();
        for (int c = 1; c <= TO - 1; c++) begin
            drive(1, 4'h0, 0, 0);
            chk($sformatf("to wait%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
            chk($sformatf("to wait%0d busy", c), 64'(busy), 64'(1));
            adv();
        end
        drive(1, 4'h0, 0, 0);
        chk("to rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        chk("to rsp_error", 64'(rsp_error), 64'(1));
        chk("to rsp_hash", 64'(rsp_hash), 64'(0));
        adv();

        // Completion on the expiry cycle wins over timeout.
        drive(1, 4'b0100, 0, 0);
        chk("tr grant", 64'(req_ready), 64'(4'b0100));
        adv();
        drive(1, 4'h0, 0, 0);
        chk("tr enable", 64'(core_enable), 64'(1));
        adv();
        for (int c = 1; c <= TO - 1; c++) begin
            drive(1, 4'h0, (c == TO - 1), (c == TO - 1) ? H7 : 32'h0);
            chk($sformatf("tr wait%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
            adv();
        end
        drive(1, 4'h0, 0, 0);
        chk("tr rsp_valid", 64'(rsp_valid), 64'(4'b0100));
        chk("tr rsp_error", 64'(rsp_error), 64'(0));
        chk("tr rsp_hash", 64'(rsp_hash), 64'(H7));
        adv();
        drive(1, 4'h0, 0, 0);
        chk("tr back idle", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
